// File: rtl/axis_mcast_demux.sv
// AXI4-Stream multicast demultiplexer: replicates each input frame to the ports
// selected by a mask captured on the first beat, with per-port handshakes and frame counters.
module axis_mcast_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,

  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,

  input  logic                          enable,
  input  logic                          drop,
  input  logic [M_COUNT-1:0]            select_mask,
  output logic [CNT_WIDTH-1:0]          fwd_frames,
  output logic [CNT_WIDTH-1:0]          drop_frames
);

  logic                  r_in_frame;
  logic [M_COUNT-1:0]    r_mask_reg;
  logic                  r_drop_reg;
  logic [M_COUNT-1:0]    r_pending;
  logic [CNT_WIDTH-1:0]  r_fwd_frames;
  logic [CNT_WIDTH-1:0]  r_drop_frames;

  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  logic                  w_done;
  logic [M_COUNT-1:0]    w_eff_mask;
  logic                  w_eff_drop;
  logic                  w_accept;
  logic [KEEP_WIDTH-1:0] w_keep_out;
  logic [USER_WIDTH-1:0] w_user_out;

  // Live select/drop apply only to the first beat; later beats reuse the latched copy.
  assign w_eff_mask = r_in_frame ? r_mask_reg : select_mask;
  assign w_eff_drop = r_in_frame ? r_drop_reg : (drop || (select_mask == '0));

  // The shared beat register may be overwritten only once every holder is taking it.
  assign w_done        = ((r_pending & ~m_axis_tready) == '0);
  assign s_axis_tready = enable && !rst && (w_eff_drop || w_done);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_frame    <= 1'b0;
      r_mask_reg    <= '0;
      r_drop_reg    <= 1'b0;
      r_pending     <= '0;
      r_fwd_frames  <= '0;
      r_drop_frames <= '0;
    end else begin
      if (w_accept && !w_eff_drop) begin
        r_pending <= w_eff_mask;
      end else begin
        r_pending <= r_pending & ~m_axis_tready;
      end

      if (w_accept) begin
        if (s_axis_tlast) begin
          r_in_frame <= 1'b0;
          if (w_eff_drop) begin
            if (r_drop_frames != '1) r_drop_frames <= r_drop_frames + CNT_WIDTH'(1);
          end else begin
            if (r_fwd_frames != '1) r_fwd_frames <= r_fwd_frames + CNT_WIDTH'(1);
          end
        end else if (!r_in_frame) begin
          r_in_frame <= 1'b1;
          r_mask_reg <= select_mask;
          r_drop_reg <= w_eff_drop;
        end
      end
    end
  end

  // NOTE: the beat register carries no reset; r_pending alone qualifies it, so
  // resetting the datapath would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_accept && !w_eff_drop) begin
      r_data <= s_axis_tdata;
      r_keep <= s_axis_tkeep;
      r_last <= s_axis_tlast;
      r_user <= s_axis_tuser;
    end
  end

  assign w_keep_out = (KEEP_ENABLE != 0) ? r_keep : {KEEP_WIDTH{1'b1}};
  assign w_user_out = (USER_ENABLE != 0) ? r_user : {USER_WIDTH{1'b0}};

  assign m_axis_tvalid = r_pending;
  assign m_axis_tdata  = {M_COUNT{r_data}};
  assign m_axis_tkeep  = {M_COUNT{w_keep_out}};
  assign m_axis_tlast  = {M_COUNT{r_last}};
  assign m_axis_tuser  = {M_COUNT{w_user_out}};

  assign fwd_frames  = r_fwd_frames;
  assign drop_frames = r_drop_frames;

endmodule

// File: tb/tb_axis_mcast_demux.sv
// Self-checking bench for axis_mcast_demux: directed scenarios plus random backpressure,
// with per-port scoreboard queues filled on input acceptance and drained on output handshakes.
module tb_axis_mcast_demux;

  localparam int M    = 4;
  localparam int DW   = 8;
  localparam int KW   = 1;
  localparam int UW   = 1;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]   s_axis_tdata  = '0;
  logic [KW-1:0]   s_axis_tkeep  = '1;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast  = 1'b0;
  logic [UW-1:0]   s_axis_tuser  = '0;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M*KW-1:0] m_axis_tkeep;
  logic [M-1:0]    m_axis_tvalid;
  logic [M-1:0]    m_axis_tready;
  logic [M-1:0]    m_axis_tlast;
  logic [M*UW-1:0] m_axis_tuser;
  logic            enable        = 1'b1;
  logic            drop          = 1'b0;
  logic [M-1:0]    select_mask   = '0;
  logic [CW-1:0]   fwd_frames;
  logic [CW-1:0]   drop_frames;

  logic [M-1:0]    dir_ready  = '0;
  logic [M-1:0]    rand_rdy   = '0;
  bit              rand_ready = 1'b0;
  assign m_axis_tready = rand_ready ? rand_rdy : dir_ready;

  axis_mcast_demux #(
    .M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_ENABLE(1),
    .USER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .drop(drop), .select_mask(select_mask),
    .fwd_frames(fwd_frames), .drop_frames(drop_frames)
  );

  int n_tests = 0;
  int n_fail  = 0;

  beat_t        sb [M][$];
  logic         m_in_frame = 1'b0;
  logic [M-1:0] m_mask     = '0;
  logic         m_drop     = 1'b0;
  int           m_fwd      = 0;
  int           m_dropc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < M; i++) rand_rdy[i] = ($urandom_range(0, 9) < 8);
  end

  // Outputs and handshakes sampled on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin : monitor
    beat_t        e;
    logic         first;
    logic [M-1:0] msk;
    logic         dr;
    if (rst) begin
      for (int i = 0; i < M; i++) sb[i].delete();
      m_in_frame = 1'b0;
      m_mask     = '0;
      m_drop     = 1'b0;
      m_fwd      = 0;
      m_dropc    = 0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("unexpected_beat_p%0d", i), 32'(m_axis_tvalid[i]), 32'h0);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("data_p%0d", i), 32'(m_axis_tdata[i*DW +: DW]), 32'(e.data));
            check($sformatf("last_p%0d", i), 32'(m_axis_tlast[i]), 32'(e.last));
            check($sformatf("user_p%0d", i), 32'(m_axis_tuser[i*UW +: UW]), 32'(e.user));
            check($sformatf("keep_p%0d", i), 32'(m_axis_tkeep[i*KW +: KW]), 32'h1);
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        first = !m_in_frame;
        msk   = first ? select_mask : m_mask;
        dr    = first ? (drop || (select_mask == '0)) : m_drop;
        if (!dr) begin
          for (int i = 0; i < M; i++)
            if (msk[i]) sb[i].push_back(beat_t'({s_axis_tdata, s_axis_tlast, s_axis_tuser}));
        end
        if (s_axis_tlast) begin
          m_in_frame = 1'b0;
          if (dr) m_dropc = (m_dropc < CMAX) ? m_dropc + 1 : CMAX;
          else    m_fwd   = (m_fwd   < CMAX) ? m_fwd   + 1 : CMAX;
        end else if (first) begin
          m_in_frame = 1'b1;
          m_mask     = msk;
          m_drop     = dr;
        end
      end
    end
  end

  // Entered and left at posedge+1; holds the beat until the DUT accepts it.
  task automatic send_beat(input logic [DW-1:0] d, input logic l,
                           input logic [M-1:0] msk, input logic dr);
    int budget = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = UW'($urandom);
    select_mask   = msk;
    drop          = dr;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && budget < 500) begin
      budget++;
      @(negedge clk);
    end
    if (!s_axis_tready) check("accept_timeout", 32'(s_axis_tready), 32'h1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && t < 500) begin
      t++;
      @(posedge clk);
    end
    #1;
    for (int i = 0; i < M; i++) check($sformatf("%s_left_p%0d", tag, i), 32'(sb[i].size()), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_axis_tvalid), 32'h0);
    check("rst_sready", 32'(s_axis_tready), 32'h0);
    check("rst_fwd", 32'(fwd_frames), 32'h0);
    check("rst_drop", 32'(drop_frames), 32'h0);
    rst = 1'b0;

    // Unicast to port 2
    dir_ready = 4'hF;
    send_beat(8'hA1, 1'b0, 4'b0100, 1'b0);
    check("uni_latency", 32'(m_axis_tvalid), 32'h4);
    send_beat(8'hA2, 1'b0, 4'b0100, 1'b0);
    send_beat(8'hA3, 1'b1, 4'b0100, 1'b0);
    check("uni_fwd", 32'(fwd_frames), 32'h1);
    drain("uni");

    // Multicast with port 3 stalled
    do_reset();
    dir_ready = 4'b0111;
    send_beat(8'hB0, 1'b0, 4'b1011, 1'b0);
    s_axis_tdata  = 8'hB1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("skew_valid0", 32'(m_axis_tvalid), 32'hB);
    check("skew_sready0", 32'(s_axis_tready), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("skew_valid_hold", 32'(m_axis_tvalid), 32'h8);
      check("skew_sready_hold", 32'(s_axis_tready), 32'h0);
    end
    @(posedge clk);
    #1;
    dir_ready = 4'hF;
    @(negedge clk);
    check("skew_sready_release", 32'(s_axis_tready), 32'h1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    drain("skew");
    check("skew_fwd", 32'(fwd_frames), 32'h1);

    // Drop case 1: explicit drop, outputs stalled
    do_reset();
    dir_ready = 4'h0;
    for (int b = 0; b < 5; b++) begin
      s_axis_tdata  = 8'(8'hD0 + b);
      s_axis_tlast  = (b == 4);
      select_mask   = 4'hF;
      drop          = (b == 0);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      check("drop_sready", 32'(s_axis_tready), 32'h1);
      check("drop_valid", 32'(m_axis_tvalid), 32'h0);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    drop = 1'b0;
    check("drop_valid_after", 32'(m_axis_tvalid), 32'h0);
    check("drop_cnt1", 32'(drop_frames), 32'h1);
    check("drop_fwd1", 32'(fwd_frames), 32'h0);

    // Drop case 2: empty mask
    send_beat(8'hD9, 1'b1, 4'b0000, 1'b0);
    check("drop_cnt2", 32'(drop_frames), 32'h2);
    check("drop_valid2", 32'(m_axis_tvalid), 32'h0);

    // Reset mid-frame with beat 1 of 3 waiting
    send_beat(8'hC0, 1'b0, 4'b0001, 1'b0);
    s_axis_tdata  = 8'hC1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("midrst_stall", 32'(s_axis_tready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(m_axis_tvalid), 32'h0);
    check("midrst_sready", 32'(s_axis_tready), 32'h0);
    check("midrst_fwd", 32'(fwd_frames), 32'h0);
    check("midrst_drop", 32'(drop_frames), 32'h0);
    rst = 1'b0;
    dir_ready = 4'hF;
    send_beat(8'hC5, 1'b1, 4'b0010, 1'b0);
    drain("midrst");
    check("midrst_newframe_fwd", 32'(fwd_frames), 32'h1);

    // Mid-frame mask change is ignored
    do_reset();
    dir_ready = 4'hF;
    send_beat(8'hE0, 1'b0, 4'b0001, 1'b0);
    send_beat(8'hE1, 1'b0, 4'b1000, 1'b0);
    send_beat(8'hE2, 1'b1, 4'b1000, 1'b0);
    send_beat(8'hE3, 1'b1, 4'b1000, 1'b0);
    drain("midchg");
    check("midchg_fwd", 32'(fwd_frames), 32'h2);

    // Counter saturation at 2 bits
    do_reset();
    for (int f = 0; f < 5; f++) send_beat(8'(8'h50 + f), 1'b1, 4'b0001, 1'b0);
    drain("sat");
    check("sat_fwd", 32'(fwd_frames), 32'h3);

    // Random masks, lengths, drops and backpressure
    do_reset();
    rand_ready = 1'b1;
    begin
      int beats = 0;
      while (beats < 10000) begin
        int           len;
        logic [M-1:0] msk;
        logic         dr;
        len = $urandom_range(1, 16);
        msk = M'($urandom);
        dr  = ($urandom_range(0, 7) == 0);
        for (int b = 0; b < len; b++) begin
          if (b == 0) send_beat(8'($urandom), (b == len - 1), msk, dr);
          else        send_beat(8'($urandom), (b == len - 1), M'($urandom), 1'($urandom));
        end
        beats += len;
      end
    end
    rand_ready = 1'b0;
    dir_ready  = 4'hF;
    drain("rand");
    check("rand_fwd", 32'(fwd_frames), 32'(m_fwd));
    check("rand_drop", 32'(drop_frames), 32'(m_dropc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
